tdp_ram_be_pipe: RTL

Single-clock true dual-port RAM with per-lane write enables, a selectable read-during-write mode, a deterministic cross-port collision policy and a configurable read pipeline with valid strobes. It is the next-generation replacement for the two-clock true dual-port RAM in shared-buffer and descriptor-table designs where both ports sit in one clock domain. Downstream logic uses the valid strobes instead of counting latency.

---
 rtl/tdp_ram_pkg.sv | 19 +
 rtl/tdp_ram_be_pipe_if.sv | 15 +
 rtl/tdp_ram_out_pipe.sv | 28 ++
 rtl/tdp_ram_be_pipe.sv | 57 +++++
 4 files changed

// File: rtl/tdp_ram_pkg.sv
// tdp_ram_pkg: mode names, lane merge and parameter legality check for tdp_ram_be_pipe
package tdp_ram_pkg;
    localparam string MODE_NO_CHANGE   = "NO_CHANGE";
    localparam string MODE_READ_FIRST  = "READ_FIRST";
    localparam string MODE_WRITE_FIRST = "WRITE_FIRST";
    localparam int    MAX_W            = 1024;
    localparam int    MAX_NB           = 128;
    function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0] old_w,
                                                    input logic [MAX_W-1:0] new_w,
                                                    input logic [MAX_NB-1:0] lane_en,
                                                    input int lane_w);
        for (int i = 0; i < MAX_W; i++)
            lane_merge[i] = lane_en[7'(i / lane_w)] ? new_w[i] : old_w[i];
    endfunction
    function automatic bit params_ok(input int width, input int depth, input int lane_w, input int rl);
        return lane_w > 0 && width > 0 && width % lane_w == 0 && width <= MAX_W &&
               width / lane_w <= MAX_NB && depth >= 2 && rl >= 1 && rl <= 4;
    endfunction
endpackage

// File: rtl/tdp_ram_be_pipe_if.sv
// tdp_ram_be_pipe_if: one RAM port (access request plus pipelined read result)
interface tdp_ram_be_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int LANE_W = 8
);
    logic                       en;
    logic [WIDTH/LANE_W-1:0]    we;
    logic [$clog2(DEPTH)-1:0]   addr;
    logic [WIDTH-1:0]           din;
    logic [WIDTH-1:0]           dout;
    logic                       valid;
    modport master (output en, we, addr, din, input dout, valid);
    modport slave  (input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/tdp_ram_out_pipe.sv
// tdp_ram_out_pipe: LAT-stage data/valid pipeline whose last stage holds while its input is invalid
module tdp_ram_out_pipe #(
    parameter int WIDTH = 32,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);
    logic [WIDTH-1:0] d [LAT];
    logic [LAT-1:0]   v;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d <= '{default: '0};
            v <= '0;
        end else begin
            v <= LAT'({v, in_valid});
            if (LAT > 1 || in_valid) d[0] <= in_data;
            for (int i = 1; i < LAT; i++)
                if (i < LAT - 1 || v[i-1]) d[i] <= d[i-1];
        end
    end
    assign dout  = d[LAT-1];
    assign valid = v[LAT-1];
endmodule

// File: rtl/tdp_ram_be_pipe.sv
// tdp_ram_be_pipe: single-clock true dual-port RAM with byte lanes, collision policy and valid-strobed read pipeline
module tdp_ram_be_pipe
    import tdp_ram_pkg::*;
#(
    parameter int    WIDTH        = 32,
    parameter int    DEPTH        = 256,
    parameter int    LANE_W       = 8,
    parameter string MODE         = MODE_NO_CHANGE,
    parameter int    READ_LATENCY = 1
) (
    input logic              clk,
    input logic              rst_n,
    tdp_ram_be_pipe_if.slave a,
    tdp_ram_be_pipe_if.slave b
);
    localparam int           NB      = WIDTH / LANE_W;
    localparam int           AW      = $clog2(DEPTH);
    localparam bit           WF      = MODE == MODE_WRITE_FIRST;
    localparam bit           NC      = MODE == MODE_NO_CHANGE;
    localparam logic [AW:0]  DEPTH_W = (AW + 1)'(DEPTH);
    if (!params_ok(WIDTH, DEPTH, LANE_W, READ_LATENCY) ||
        !(NC || WF || MODE == MODE_READ_FIRST)) begin : g_bad_params
        $error("tdp_ram_be_pipe: illegal parameter combination");
    end
    logic [WIDTH-1:0] mem [DEPTH];
    logic             a_ok, b_ok, a_rv, b_rv;
    logic [NB-1:0]    a_wl, b_wl;
    logic [WIDTH-1:0] a_old, b_old, a_res, b_res;
    // Old words are read before the edge, so a cross-port reader always sees pre-write data.
    always_comb begin
        a_ok  = {1'b0, a.addr} < DEPTH_W;
        b_ok  = {1'b0, b.addr} < DEPTH_W;
        a_wl  = (a.en && a_ok) ? a.we : '0;
        b_wl  = (b.en && b_ok) ? b.we : '0;
        a_old = a_ok ? mem[a.addr] : '0;
        b_old = b_ok ? mem[b.addr] : '0;
        a_res = (WF && |a.we) ? WIDTH'(lane_merge(MAX_W'(a_old), MAX_W'(a.din), MAX_NB'(a.we), LANE_W)) : a_old;
        b_res = (WF && |b.we) ? WIDTH'(lane_merge(MAX_W'(b_old), MAX_W'(b.din), MAX_NB'(b.we), LANE_W)) : b_old;
        a_rv  = a.en && (!NC || ~|a.we);
        b_rv  = b.en && (!NC || ~|b.we);
    end
    // Port A's lane update is scheduled last, so it wins a same-address, same-lane collision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NB; i++) begin
                if (b_wl[i]) mem[b.addr][i*LANE_W +: LANE_W] <= b.din[i*LANE_W +: LANE_W];
                if (a_wl[i]) mem[a.addr][i*LANE_W +: LANE_W] <= a.din[i*LANE_W +: LANE_W];
            end
        end
    end
    tdp_ram_out_pipe #(.WIDTH(WIDTH), .LAT(READ_LATENCY)) u_pipe_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_res), .in_valid(a_rv), .dout(a.dout), .valid(a.valid)
    );
    tdp_ram_out_pipe #(.WIDTH(WIDTH), .LAT(READ_LATENCY)) u_pipe_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_res), .in_valid(b_rv), .dout(b.dout), .valid(b.valid)
    );
endmodule
